// File: rtl/char_column_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | char_column_sequencer                                                      |
// | Fetches 5x7 glyph bitmaps from the char ROM and streams them as column     |
// | words with trailing blank gap columns; one pending char can be queued.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module char_column_sequencer #(
  parameter int ROWS       = 7,
  parameter int COLS       = 5,
  parameter int DATA_WIDTH = 35,
  parameter int GAP_COLS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_char,
  output logic [6:0]            rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  col_valid,
  input  logic                  col_ready,
  output logic [ROWS-1:0]       col_data,
  output logic                  col_last,
  output logic                  busy
);

  localparam int c_total_cols = COLS + GAP_COLS;
  localparam int c_idx_w      = $clog2(c_total_cols + 1);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_total_cols - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_COLS  = 2'd2
  } state_t;

  state_t                r_state;
  logic [6:0]            r_rom_addr;
  logic [DATA_WIDTH-1:0] r_bitmap;
  logic                  r_pend;
  logic [c_idx_w-1:0]    r_idx;

  logic                  w_accept;
  logic [ROWS-1:0]       w_col;

  // in_ready never looks at col_ready, so there is no in_valid->in_ready path
  assign in_ready  = !rst && !clear &&
                     ((r_state == S_IDLE) || ((r_state == S_COLS) && !r_pend));
  assign w_accept  = in_valid && in_ready;
  assign rom_addr  = r_rom_addr;
  assign col_valid = (r_state == S_COLS);
  assign col_last  = (r_state == S_COLS) && (r_idx == c_last_idx);
  assign col_data  = (r_state == S_COLS) ? w_col : '0;
  assign busy      = (r_state != S_IDLE) || r_pend;

  // Top-left pixel is the MSB; gap indices match no glyph column and read zero.
  always_comb begin
    w_col = '0;
    for (int c = 0; c < COLS; c++) begin
      if (r_idx == c_idx_w'(c)) begin
        for (int r = 0; r < ROWS; r++) begin
          w_col[r] = r_bitmap[DATA_WIDTH-1-(COLS*r+c)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rom_addr <= '0;
      r_bitmap   <= '0;
      r_pend     <= 1'b0;
      r_idx      <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rom_addr <= in_char;
            r_state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          r_bitmap <= rom_data;
          r_idx    <= '0;
          r_state  <= S_COLS;
        end
        S_COLS: begin
          // Bitmap is already latched, so the ROM address is free to move on.
          if (w_accept) begin
            r_rom_addr <= in_char;
            r_pend     <= 1'b1;
          end
          if (col_ready) begin
            if (r_idx == c_last_idx) begin
              r_idx <= '0;
              if (r_pend || w_accept) begin
                r_pend  <= 1'b0;
                r_state <= S_FETCH;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_char_column_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_char_column_sequencer                                                   |
// | Directed bench for char_column_sequencer with a stub glyph ROM.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_char_column_sequencer;

  logic        clk = 1'b0;
  logic        rst, clear, in_valid, in_valid2, col_ready;
  logic [6:0]  in_char;
  logic        in_ready, in_ready2, col_valid, col_valid2, col_last, col_last2, busy, busy2;
  logic [6:0]  rom_addr, rom_addr2, col_data, col_data2;
  logic [34:0] rom_data, rom_data2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [6:0] q_data[$];
  logic       q_last[$];
  int         q_cyc[$];
  logic [6:0] q2_data[$];
  logic       q2_last[$];
  logic [6:0] exp_d[$];
  logic       exp_l[$];

  always #5 clk = ~clk;

  function automatic logic [34:0] stub_rom(input logic [6:0] a);
    case (a)
      7'h41:   return 35'h4_0000_0000;
      7'h42:   return 35'h0_0000_0001;
      7'h43:   return 35'h7_C000_0000;
      7'h44:   return 35'h1_0842_1084;
      default: return 35'h0;
    endcase
  endfunction

  assign rom_data  = stub_rom(rom_addr);
  assign rom_data2 = stub_rom(rom_addr2);

  char_column_sequencer #(.ROWS(7), .COLS(5), .DATA_WIDTH(35), .GAP_COLS(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .rom_addr(rom_addr), .rom_data(rom_data), .col_valid(col_valid),
    .col_ready(col_ready), .col_data(col_data), .col_last(col_last), .busy(busy)
  );

  char_column_sequencer #(.ROWS(7), .COLS(5), .DATA_WIDTH(35), .GAP_COLS(0)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_char(in_char), .rom_addr(rom_addr2), .rom_data(rom_data2), .col_valid(col_valid2),
    .col_ready(col_ready), .col_data(col_data2), .col_last(col_last2), .busy(busy2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!rst && col_valid && col_ready) begin
      q_data.push_back(col_data);
      q_last.push_back(col_last);
      q_cyc.push_back(cyc);
    end
    if (!rst && col_valid2 && col_ready) begin
      q2_data.push_back(col_data2);
      q2_last.push_back(col_last2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, 64'(q_data.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < q_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(exp_d[i]));
      check($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(exp_l[i]));
    end
  endtask

  task automatic send_char(input logic [6:0] c);
    in_valid = 1'b1;
    in_char  = c;
    #1;
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    check("send_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100 && busy; k++) tick();
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
    in_char = 7'h00; col_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_in_ready2", 64'(in_ready2), 64'd0);
    check("rst_col_valid", 64'(col_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_col_data",  64'(col_data),  64'd0);
    check("rst_col_last",  64'(col_last),  64'd0);
    check("rst_rom_addr",  64'(rom_addr),  64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 'A' cycle by cycle: accept, FETCH bubble, then six columns.
    in_valid = 1'b1; in_char = 7'h41;
    #1;
    check("a_in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("a_fetch_col_valid", 64'(col_valid), 64'd0);
    check("a_fetch_busy",      64'(busy),      64'd1);
    check("a_fetch_rom_addr",  64'(rom_addr),  64'h41);
    tick();
    exp_d = '{7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    for (int i = 0; i < 6; i++) begin
      check($sformatf("a_col_valid%0d", i), 64'(col_valid), 64'd1);
      check($sformatf("a_col_data%0d", i),  64'(col_data),  64'(exp_d[i]));
      check($sformatf("a_col_last%0d", i),  64'(col_last),  64'(i == 5));
      tick();
    end
    check("a_done_col_valid", 64'(col_valid), 64'd0);
    check("a_done_busy",      64'(busy),      64'd0);
    check("a_done_in_ready",  64'(in_ready),  64'd1);

    // Bottom-right pixel lands in column 4, row 6.
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_char(7'h42);
    wait_idle();
    exp_d = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("b");

    // Back-to-back A then B through the pending register.
    q_data.delete(); q_last.delete(); q_cyc.delete();
    in_valid = 1'b1; in_char = 7'h41;
    #1;
    check("ab_ready_idle", 64'(in_ready), 64'd1);
    tick();
    in_char = 7'h42;
    #1;
    check("ab_ready_fetch", 64'(in_ready), 64'd0);
    tick();
    check("ab_ready_cols", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("ab_ready_pending", 64'(in_ready), 64'd0);
    check("ab_busy_pending",  64'(busy),     64'd1);
    wait_idle();
    exp_d = '{7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
              7'h00, 7'h00, 7'h00, 7'h00, 7'h40, 7'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("ab");
    if (q_cyc.size() >= 7) check("ab_bubble", 64'(q_cyc[6] - q_cyc[5]), 64'd2);
    else check("ab_bubble_missing", 64'(q_cyc.size()), 64'd12);

    // Stall three cycles on the full-height column 2 of 'D'.
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_char(7'h44);
    tick(); tick(); tick();
    col_ready = 1'b0;
    #1;
    check("stall_data0",  64'(col_data),  64'h7f);
    check("stall_last0",  64'(col_last),  64'd0);
    check("stall_valid0", 64'(col_valid), 64'd1);
    for (int i = 1; i < 3; i++) begin
      tick();
      check($sformatf("stall_data%0d", i),  64'(col_data),  64'h7f);
      check($sformatf("stall_valid%0d", i), 64'(col_valid), 64'd1);
    end
    col_ready = 1'b1;
    wait_idle();
    exp_d = '{7'h00, 7'h00, 7'h7f, 7'h00, 7'h00, 7'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("stall");

    // Clear at column 3 with 'B' pending and 'C' offered alongside.
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_char(7'h41);
    tick();
    in_valid = 1'b1; in_char = 7'h42;
    #1;
    check("clr_pend_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    clear = 1'b1; in_valid = 1'b1; in_char = 7'h43;
    #1;
    check("clr_in_ready", 64'(in_ready), 64'd0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    #1;
    check("clr_col_valid", 64'(col_valid), 64'd0);
    check("clr_busy",      64'(busy),      64'd0);
    check("clr_in_ready_after", 64'(in_ready), 64'd1);
    repeat (8) tick();
    exp_d = '{7'h01, 7'h00, 7'h00, 7'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0};
    check_stream("clr");

    // Control code streams blank columns; reset mid-glyph then recover.
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_char(7'h1f);
    wait_idle();
    exp_d = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("ctl");
    send_char(7'h1f);
    tick(); tick();
    check("ctl_in_cols", 64'(col_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("mid_rst_col_valid", 64'(col_valid), 64'd0);
    check("mid_rst_busy",      64'(busy),      64'd0);
    check("mid_rst_rom_addr",  64'(rom_addr),  64'd0);
    check("mid_rst_col_data",  64'(col_data),  64'd0);
    check("mid_rst_col_last",  64'(col_last),  64'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready_after", 64'(in_ready), 64'd1);
    q_data.delete(); q_last.delete(); q_cyc.delete();
    send_char(7'h43);
    wait_idle();
    exp_d = '{7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h00};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("c");

    // No gap columns: exactly five words, last flagged on the fifth.
    q2_data.delete(); q2_last.delete();
    in_valid2 = 1'b1; in_char = 7'h42;
    #1;
    check("gap0_in_ready", 64'(in_ready2), 64'd1);
    tick();
    in_valid2 = 1'b0;
    for (int k = 0; k < 100 && busy2; k++) tick();
    check("gap0_idle_timeout", 64'(busy2), 64'd0);
    q_data = q2_data;
    q_last = q2_last;
    exp_d = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h40};
    exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("gap0");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
